hex_scroll_ctrl: RTL and testbench

Sequencer for the DE-board four-digit seven-segment display that scrolls a fixed 8-character message ("HELLO" plus three blanks) across HEX3..HEX0. It contains the ~1 s prescaler, a 3-bit scroll-position counter, and a run/idle/step state machine. The 7-segment lookup is built in. It replaces ad-hoc clear-on-terminal-count counter chains with a single-clock, resettable controller that supports pause, direction and single-step.

---
 rtl/hex_scroll_ctrl.sv | 153 +++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl
//   Scrolls the 8-character message "HELLO   " across a four-digit
//   seven-segment display. A prescaler paces automatic scrolling; the
//   run/idle/step FSM adds pause and single-step. Direction is selectable.
//
// Ports
//   CLOCK_50          in   system clock, rising-edge
//   RESETN            in   asynchronous active-low reset
//   run               in   async level, 1 = auto-scroll
//   dir               in   async level, 0 = left (pos+1), 1 = right (pos-1)
//   step_req          in   async, rising edge requests one step while idle
//   pos[2:0]          out  message index shown on HEX3
//   tick              out  one-cycle pulse ahead of each automatic advance
//   HEX3..HEX0[6:0]   out  active-low segments, bit0=a .. bit6=g

// One display digit: message ROM lookup plus segment encoding.
module hex_scroll_digit (
  input  logic [2:0] i_idx,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_idx)
      3'd0:    o_seg = 7'b0001001; // H
      3'd1:    o_seg = 7'b0000110; // E
      3'd2:    o_seg = 7'b1000111; // L
      3'd3:    o_seg = 7'b1000111; // L
      3'd4:    o_seg = 7'b1000000; // O
      default: o_seg = 7'b1111111; // blank
    endcase
  end
endmodule

module hex_scroll_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESETN,
  input  logic       run,
  input  logic       dir,
  input  logic       step_req,
  output logic [2:0] pos,
  output logic       tick,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam int          NUM_DIG = 4;
  localparam logic [25:0] TERM    = 26'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

  state_t      r_state, w_state_nxt;
  logic [25:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_pos, w_pos_nxt;
  logic        w_adv, w_tick;

  // 2-FF synchronizers; bit 1 is the usable (second-stage) value.
  logic [1:0]  r_run_sync, r_dir_sync, r_step_sync;
  logic        r_step_prev;
  logic        w_run_s, w_dir_s, w_step_s, w_step_rise;

  assign w_run_s     = r_run_sync[1];
  assign w_dir_s     = r_dir_sync[1];
  assign w_step_s    = r_step_sync[1];
  assign w_step_rise = w_step_s & ~r_step_prev;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_run_sync  <= '0;
      r_dir_sync  <= '0;
      r_step_sync <= '0;
      r_step_prev <= 1'b0;
    end else begin
      r_run_sync  <= {r_run_sync[0],  run};
      r_dir_sync  <= {r_dir_sync[0],  dir};
      r_step_sync <= {r_step_sync[0], step_req};
      r_step_prev <= w_step_s;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adv       = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        // run wins over a coincident step request; the step is dropped.
        if (w_run_s)          w_state_nxt = S_RUN;
        else if (w_step_rise) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        // Stopping beats a terminal count on the same edge.
        if (!w_run_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TERM) begin
          w_tick    = 1'b1;
          w_adv     = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end
      S_STEP: begin
        w_adv       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // dir_s is sampled on the advancing edge; 3-bit wrap in both directions.
  assign w_pos_nxt = !w_adv  ? r_pos :
                     w_dir_s ? r_pos - 3'd1 : r_pos + 3'd1;

  assign pos  = r_pos;
  assign tick = w_tick;

  // Digit k shows msg[pos+k]; digit 0 drives HEX3.
  logic [NUM_DIG-1:0][6:0] w_seg;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    logic [2:0] w_idx;
    assign w_idx = r_pos + 3'(g);
    hex_scroll_digit u_dig (
      .i_idx (w_idx),
      .o_seg (w_seg[g])
    );
  end

  assign HEX3 = w_seg[0];
  assign HEX2 = w_seg[1];
  assign HEX1 = w_seg[2];
  assign HEX0 = w_seg[3];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
module tb_hex_scroll_ctrl;

  localparam int T = 4;

  localparam logic [6:0] SH = 7'b0001001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SL = 7'b1000111;
  localparam logic [6:0] SO = 7'b1000000;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       RESETN, run, dir, step_req;
  logic [2:0] pos;
  logic       tick;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] pos;
    int         cyc;
    bit         is_auto;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] last_pos;
  logic       prev_tick;

  hex_scroll_ctrl #(.TICK_DIV(T)) dut (
    .CLOCK_50 (clk),
    .RESETN   (RESETN),
    .run      (run),
    .dir      (dir),
    .step_req (step_req),
    .pos      (pos),
    .tick     (tick),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .HEX1     (HEX1),
    .HEX0     (HEX0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] rom(input logic [2:0] i);
    logic [6:0] tbl [8];
    tbl = '{SH, SE, SL, SL, SO, SB, SB, SB};
    return tbl[i];
  endfunction

  function automatic logic [27:0] exp_hex(input logic [2:0] p);
    logic [2:0] p1, p2, p3;
    p1 = p + 3'd1; p2 = p + 3'd2; p3 = p + 3'd3;
    return {rom(p), rom(p1), rom(p2), rom(p3)};
  endfunction

  task automatic push(input logic [2:0] p, input int c, input bit a);
    exp_t e;
    e.pos = p; e.cyc = c; e.is_auto = a;
    sb.push_back(e);
  endtask

  // Scoreboard: runs #1 after every edge; any pos change must match the
  // queue head (value, edge, preceded-by-tick), and tick must never fire
  // without an advance on the following edge.
  task automatic sample_cycle();
    exp_t e;
    if (pos !== last_pos) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_advance cyc=%0d pos=%0d was=%0d", cyc, pos, last_pos);
      end else begin
        e = sb.pop_front();
        if (pos !== e.pos || cyc != e.cyc) begin
          errors++;
          $display("FAIL advance got pos=%0d at cyc=%0d, want pos=%0d at cyc=%0d",
                   pos, cyc, e.pos, e.cyc);
        end
        checks++;
        if (prev_tick !== e.is_auto) begin
          errors++;
          $display("FAIL tick_before_advance cyc=%0d got=%b want=%b", cyc, prev_tick, e.is_auto);
        end
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(e.pos)) begin
          errors++;
          $display("FAIL hex_follow cyc=%0d got=%h want=%h", cyc,
                   {HEX3, HEX2, HEX1, HEX0}, exp_hex(e.pos));
        end
      end
    end else if (prev_tick === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_without_advance cyc=%0d pos=%0d", cyc, pos);
    end
    last_pos  = pos;
    prev_tick = tick;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk); #1;
      sample_cycle();
    end
  endtask

  task automatic check_drained(input string name, input logic [2:0] want);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_advances got=%0d pending want=0", name, sb.size());
    end
    checks++;
    if (pos !== want) begin
      errors++;
      $display("FAIL %s_final_pos got=%0d want=%0d", name, pos, want);
    end
  endtask

  task automatic check_reset_view(input string name);
    checks++;
    if (pos !== 3'd0) begin errors++; $display("FAIL %s_pos got=%0d want=0", name, pos); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL %s_tick got=%b want=0", name, tick); end
    checks++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {SH, SE, SL, SL}) begin
      errors++;
      $display("FAIL %s_hex got=%h want=%h", name, {HEX3, HEX2, HEX1, HEX0}, {SH, SE, SL, SL});
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0; run = 1'b0; dir = 1'b0; step_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_view("reset_hold");
    RESETN    = 1'b1;
    last_pos  = pos;
    prev_tick = tick;
    wait_cyc(cyc + 12);
    check_drained("reset_idle", 3'd0);
  endtask

  int m;

  task automatic test_scroll_left();
    int c0;
    c0 = cyc;
    run = 1'b1; dir = 1'b0;
    m = c0 + 3;
    for (int k = 1; k <= 8; k++) push(3'(k), m + T * k, 1'b1);
    wait_cyc(m + 16);
    checks++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {SO, SB, SB, SB}) begin
      errors++;
      $display("FAIL left_pos4_display got=%h want=%h", {HEX3, HEX2, HEX1, HEX0}, {SO, SB, SB, SB});
    end
    wait_cyc(m + 28);
    checks++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {SB, SH, SE, SL}) begin
      errors++;
      $display("FAIL left_pos7_display got=%h want=%h", {HEX3, HEX2, HEX1, HEX0}, {SB, SH, SE, SL});
    end
    wait_cyc(m + 32);
    check_drained("left", 3'd0);
  endtask

  task automatic test_scroll_right();
    dir = 1'b1;
    push(3'd7, m + 36, 1'b1);
    push(3'd6, m + 40, 1'b1);
    push(3'd5, m + 44, 1'b1);
    wait_cyc(m + 46);
    // Too late for the m+48 advance (still decrements); m+52 increments.
    dir = 1'b0;
    push(3'd4, m + 48, 1'b1);
    push(3'd5, m + 52, 1'b1);
    wait_cyc(m + 52);
    check_drained("right", 3'd5);
  endtask

  task automatic test_pause();
    int a, r;
    a = cyc;
    run = 1'b0;            // leaves RUN on edge a+3 with cnt=2
    wait_cyc(a + 16);
    check_drained("pause_hold", 3'd5);
    r = cyc;
    run = 1'b1;
    push(3'd6, r + 3 + T, 1'b1);
    push(3'd7, r + 3 + 2 * T, 1'b1);
    wait_cyc(r + 3 + 2 * T);
    run = 1'b0;
    wait_cyc(r + 24);
    check_drained("pause_resume", 3'd7);
  endtask

  task automatic test_step();
    int s;
    s = cyc;
    step_req = 1'b1;
    push(3'd0, s + 4, 1'b0);
    wait_cyc(s + 3);
    step_req = 1'b0;
    wait_cyc(s + 14);
    check_drained("step_once", 3'd0);
    s = cyc;
    step_req = 1'b1;
    push(3'd1, s + 4, 1'b0);
    wait_cyc(s + 1);
    step_req = 1'b0;
    wait_cyc(s + 12);
    check_drained("step_rearm", 3'd1);
    s = cyc;
    run = 1'b1;
    push(3'd2, s + 3 + T, 1'b1);
    push(3'd3, s + 3 + 2 * T, 1'b1);
    wait_cyc(s + 4);
    step_req = 1'b1;
    wait_cyc(s + 7);
    step_req = 1'b0;
    wait_cyc(s + 3 + 2 * T);
    run = 1'b0;
    wait_cyc(s + 24);
    check_drained("step_in_run", 3'd3);
  endtask

  task automatic test_simultaneous();
    int s;
    s = cyc;
    run = 1'b1; step_req = 1'b1;
    push(3'd4, s + 3 + T, 1'b1);
    push(3'd5, s + 3 + 2 * T, 1'b1);
    wait_cyc(s + 3 + 2 * T);
    run = 1'b0; step_req = 1'b0;
    wait_cyc(s + 24);
    check_drained("simul", 3'd5);
  endtask

  task automatic test_reset_midrun();
    int s;
    s = cyc;
    run = 1'b1;
    push(3'd6, s + 3 + T, 1'b1);
    wait_cyc(s + 9);
    check_drained("midrun_pre", 3'd6);
    RESETN = 1'b0;
    #1;
    check_reset_view("midrun_reset");
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESETN    = 1'b1;
    last_pos  = pos;
    prev_tick = tick;
    wait_cyc(cyc + 12);
    check_drained("midrun_after", 3'd0);
  endtask

  initial begin
    test_reset();
    test_scroll_left();
    test_scroll_right();
    test_pause();
    test_step();
    test_simultaneous();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
